coriolis_fpadd_share_arb: RTL



---
 rtl/coriolis_fpadd_share_arb.sv | 144 ++++++++++++++
 1 files changed

// File: rtl/coriolis_fpadd_share_arb.sv
// ---------------------------------------------------------------------------
// coriolis_fpadd_share_arb
//
// Purpose:
//   Shares one pipelined FP adder (34-bit FloPoCo-style operands) among NREQ
//   leaf streams. Operand pairs are granted one per cycle, registered onto
//   add_x/add_y, and tracked by a tag pipe that runs alongside the adder. The
//   tag at the head of the pipe steers the adder result to its owner. When
//   the owner cannot take the result, the whole adder and tag pipe freeze.
//
// Configuration:
//   CORIOLIS_ARB_FIXED_PRIO_EN defined   : fixed priority, lowest index wins,
//                                          no round-robin pointer.
//   CORIOLIS_ARB_FIXED_PRIO_EN undefined : round-robin arbitration (default).
//
// Ports:
//   clk        clock
//   rst        synchronous active-high reset
//   ivalid     per-requester operand-pair valid            [NREQ]
//   iready     per-requester accept (one-hot or zero)      [NREQ]
//   in1, in2   flattened X/Y operands, req k at k*STREAMW  [NREQ*STREAMW]
//   ovalid     one-hot result valid by owning requester    [NREQ]
//   out1       shared result bus (pass-through of add_r)   [STREAMW]
//   oready     per-requester result ready                  [NREQ]
//   add_x/y    registered operands to the adder            [STREAMW]
//   add_stall  freezes every adder stage while high
//   add_r      adder result                                [STREAMW]
// ---------------------------------------------------------------------------
module coriolis_fpadd_share_arb #(
  parameter int NREQ    = 4,
  parameter int STREAMW = 34,
  parameter int LAT     = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NREQ-1:0]         ivalid,
  output logic [NREQ-1:0]         iready,
  input  logic [NREQ*STREAMW-1:0] in1,
  input  logic [NREQ*STREAMW-1:0] in2,
  output logic [NREQ-1:0]         ovalid,
  output logic [STREAMW-1:0]      out1,
  input  logic [NREQ-1:0]         oready,
  output logic [STREAMW-1:0]      add_x,
  output logic [STREAMW-1:0]      add_y,
  output logic                    add_stall,
  input  logic [STREAMW-1:0]      add_r
);

  localparam int TAGW = $clog2(NREQ);

  // Tag pipe: stage 0 lines up with add_x/add_y, stage LAT with add_r.
  logic [LAT:0]      r_vld;
  logic [TAGW-1:0]   r_tag [0:LAT];
  logic [STREAMW-1:0] r_add_x;
  logic [STREAMW-1:0] r_add_y;

  logic              w_stall;
  logic              w_found;
  logic [TAGW-1:0]   w_grant;
  logic [NREQ-1:0]   w_grant_oh;

`ifndef CORIOLIS_ARB_FIXED_PRIO_EN
  logic [TAGW-1:0]   r_ptr;
  int                w_idx;
`endif

  // Head result cannot leave: freeze adder, tag pipe and arbitration.
  assign w_stall = r_vld[LAT] & ~oready[r_tag[LAT]];

  always_comb begin
    w_found    = 1'b0;
    w_grant    = '0;
    w_grant_oh = '0;
`ifdef CORIOLIS_ARB_FIXED_PRIO_EN
    for (int k = 0; k < NREQ; k++) begin
      if (!w_found && ivalid[k]) begin
        w_found = 1'b1;
        w_grant = TAGW'(k);
      end
    end
`else
    w_idx = 0;
    // Search upward from the pointer, wrapping at NREQ.
    for (int off = 0; off < NREQ; off++) begin
      w_idx = int'(r_ptr) + off;
      if (w_idx >= NREQ) w_idx = w_idx - NREQ;
      if (!w_found && ivalid[w_idx]) begin
        w_found = 1'b1;
        w_grant = TAGW'(w_idx);
      end
    end
`endif
    if (w_stall) w_found = 1'b0;
    if (w_found) w_grant_oh[w_grant] = 1'b1;
  end

  assign iready = w_grant_oh;

  // Control state: valid bits, operand registers, pointer.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_vld   <= '0;
      r_add_x <= '0;
      r_add_y <= '0;
`ifndef CORIOLIS_ARB_FIXED_PRIO_EN
      r_ptr   <= '0;
`endif
    end else if (!w_stall) begin
      r_vld <= {r_vld[LAT-1:0], w_found};
      if (w_found) begin
        r_add_x <= in1[int'(w_grant)*STREAMW +: STREAMW];
        r_add_y <= in2[int'(w_grant)*STREAMW +: STREAMW];
`ifndef CORIOLIS_ARB_FIXED_PRIO_EN
        if (int'(w_grant) == NREQ-1) r_ptr <= '0;
        else                         r_ptr <= w_grant + 1'b1;
`endif
      end
    end
  end

  // Tag payload needs no reset: it is only observed behind a valid bit.
  always_ff @(posedge clk) begin
    if (!w_stall) r_tag[0] <= w_grant;
  end

  generate
    for (genvar gi = 1; gi <= LAT; gi++) begin : g_tag_pipe
      always_ff @(posedge clk) begin
        if (!w_stall) r_tag[gi] <= r_tag[gi-1];
      end
    end
  endgenerate

  always_comb begin
    ovalid = '0;
    if (r_vld[LAT]) ovalid[r_tag[LAT]] = 1'b1;
  end

  assign out1      = add_r;
  assign add_x     = r_add_x;
  assign add_y     = r_add_y;
  assign add_stall = w_stall;

endmodule
